// File: rtl/pkt_queue_demux.sv
// pkt_queue_demux
// Steers one AXI4-Stream packet stream into four per-queue output streams.
// The queue is chosen from a tuser bit-field on the first beat of a packet
// and held for the rest of that packet.
// Packets whose queue index is out of range (>= C_NUM_QUEUES) are dropped whole.
// A single registered output stage gives one-cycle latency at full throughput.
// The output ready is passed back combinationally as s_axis_tready.
// Optional build macro QUEUE_DEMUX_CNT_EN enables the per-queue packet
// counters and the drop counter. Without it those outputs are tied to zero.

`timescale 1ns/1ps

module pkt_queue_demux #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_QUEUES       = 4,
    parameter int C_NUM_QUEUES_WIDTH = 2,
    parameter int C_QSEL_LSB         = 24
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_0,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
    output logic                            m_axis_tlast_0,
    output logic                            m_axis_tvalid_0,
    input  logic                            m_axis_tready_0,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_1,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
    output logic                            m_axis_tlast_1,
    output logic                            m_axis_tvalid_1,
    input  logic                            m_axis_tready_1,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_2,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
    output logic                            m_axis_tlast_2,
    output logic                            m_axis_tvalid_2,
    input  logic                            m_axis_tready_2,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_3,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
    output logic                            m_axis_tlast_3,
    output logic                            m_axis_tvalid_3,
    input  logic                            m_axis_tready_3,

    output logic [31:0]                     pkt_cnt_0,
    output logic [31:0]                     pkt_cnt_1,
    output logic [31:0]                     pkt_cnt_2,
    output logic [31:0]                     pkt_cnt_3,
    output logic [31:0]                     drop_cnt
);

    localparam int LP_KW  = C_AXIS_DATA_WIDTH / 8;
    // Queue select padded by two bits so it can be range-checked and
    // narrowed to the 2-bit physical queue index for any field width.
    localparam int LP_QPW = C_NUM_QUEUES_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_SOP  = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [C_NUM_QUEUES_WIDTH-1:0]   w_qsel;
    logic [LP_QPW-1:0]               w_qsel_pad;
    logic                            w_qsel_ok;
    logic [1:0]                      w_qsel_idx;

    logic [3:0]                      w_m_tready;
    logic                            w_out_rdy;
    logic                            w_drain;
    logic                            w_s_tready;
    logic                            w_acc;
    logic                            w_load;
    logic                            w_cur_upd;
    logic [1:0]                      w_load_q;

    logic                            r_out_vld;
    logic [1:0]                      r_out_q;
    logic [1:0]                      r_cur_q;
    logic [C_AXIS_DATA_WIDTH-1:0]    r_tdata;
    logic [LP_KW-1:0]                r_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]   r_tuser;
    logic                            r_tlast;

    assign w_qsel     = s_axis_tuser[C_QSEL_LSB +: C_NUM_QUEUES_WIDTH];
    assign w_qsel_pad = {2'b00, w_qsel};
    assign w_qsel_ok  = (w_qsel_pad < LP_QPW'(C_NUM_QUEUES));
    assign w_qsel_idx = w_qsel_pad[1:0];

    assign w_m_tready = {m_axis_tready_3, m_axis_tready_2,
                         m_axis_tready_1, m_axis_tready_0};

    // Output drain, input ready/accept, and the SOP/FWD/DROP next-state decision.
    always_comb begin
        w_out_rdy   = w_m_tready[r_out_q];
        w_drain     = r_out_vld & w_out_rdy;
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cur_upd   = 1'b0;
        w_load_q    = r_cur_q;
        if (r_state == ST_DROP) begin
            w_s_tready = 1'b1;
        end else begin
            // The stage can take a beat when empty or when emptying this cycle.
            w_s_tready = ~r_out_vld | w_out_rdy;
        end
        w_acc = s_axis_tvalid & w_s_tready;

        case (r_state)
            ST_SOP: begin
                if (w_acc) begin
                    if (w_qsel_ok) begin
                        w_load    = 1'b1;
                        w_cur_upd = 1'b1;
                        w_load_q  = w_qsel_idx;
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_SOP;
                        end else begin
                            w_state_nxt = ST_FWD;
                        end
                    end else begin
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_SOP;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end else begin
                    w_state_nxt = ST_SOP;
                end
            end
            ST_FWD: begin
                if (w_acc) begin
                    // The rest of the packet follows the latched queue.
                    // tuser on these beats is not used for steering.
                    w_load = 1'b1;
                    if (s_axis_tlast) begin
                        w_state_nxt = ST_SOP;
                    end else begin
                        w_state_nxt = ST_FWD;
                    end
                end else begin
                    w_state_nxt = ST_FWD;
                end
            end
            ST_DROP: begin
                if (w_acc && s_axis_tlast) begin
                    w_state_nxt = ST_SOP;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_SOP;
            end
        endcase
    end

    // Packet state register. A reset mid-packet returns to SOP and
    // abandons the partial packet.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_SOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Queue latched at start of packet. It is held until the next accepted first beat.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_cur_q <= 2'd0;
        end else if (w_cur_upd) begin
            r_cur_q <= w_qsel_idx;
        end else begin
            r_cur_q <= r_cur_q;
        end
    end

    // Output stage occupancy and destination.
    // A load wins over a drain so back-to-back beats flow without a bubble.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_vld <= 1'b0;
            r_out_q   <= 2'd0;
        end else if (w_load) begin
            r_out_vld <= 1'b1;
            r_out_q   <= w_load_q;
        end else if (w_drain) begin
            r_out_vld <= 1'b0;
            r_out_q   <= r_out_q;
        end else begin
            r_out_vld <= r_out_vld;
            r_out_q   <= r_out_q;
        end
    end

    // Output beat contents. These are held stable until the next load.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata <= '0;
            r_tkeep <= '0;
            r_tuser <= '0;
            r_tlast <= 1'b0;
        end else if (w_load) begin
            r_tdata <= s_axis_tdata;
            r_tkeep <= s_axis_tkeep;
            r_tuser <= s_axis_tuser;
            r_tlast <= s_axis_tlast;
        end else begin
            r_tdata <= r_tdata;
            r_tkeep <= r_tkeep;
            r_tuser <= r_tuser;
            r_tlast <= r_tlast;
        end
    end

    assign s_axis_tready = w_s_tready;

    assign m_axis_tdata_0  = r_tdata;
    assign m_axis_tkeep_0  = r_tkeep;
    assign m_axis_tuser_0  = r_tuser;
    assign m_axis_tlast_0  = r_tlast;
    assign m_axis_tvalid_0 = r_out_vld & (r_out_q == 2'd0);

    assign m_axis_tdata_1  = r_tdata;
    assign m_axis_tkeep_1  = r_tkeep;
    assign m_axis_tuser_1  = r_tuser;
    assign m_axis_tlast_1  = r_tlast;
    assign m_axis_tvalid_1 = r_out_vld & (r_out_q == 2'd1);

    assign m_axis_tdata_2  = r_tdata;
    assign m_axis_tkeep_2  = r_tkeep;
    assign m_axis_tuser_2  = r_tuser;
    assign m_axis_tlast_2  = r_tlast;
    assign m_axis_tvalid_2 = r_out_vld & (r_out_q == 2'd2);

    assign m_axis_tdata_3  = r_tdata;
    assign m_axis_tkeep_3  = r_tkeep;
    assign m_axis_tuser_3  = r_tuser;
    assign m_axis_tlast_3  = r_tlast;
    assign m_axis_tvalid_3 = r_out_vld & (r_out_q == 2'd3);

`ifdef QUEUE_DEMUX_CNT_EN
    logic [31:0] r_pkt_cnt [4];
    logic [31:0] r_drop_cnt;
    logic [3:0]  w_pkt_done;
    logic        w_drop_pkt;

    // A dropped packet is counted once, when its first beat is accepted.
    assign w_drop_pkt = w_acc & (r_state == ST_SOP) & ~w_qsel_ok;

    // A packet completes on a queue when that queue takes the tlast beat.
    always_comb begin
        w_pkt_done = 4'd0;
        for (int q = 0; q < 4; q++) begin
            w_pkt_done[q] = r_out_vld & r_tlast & w_m_tready[q] & (r_out_q == 2'(q));
        end
    end

    // Per-queue forwarded packet counters. They wrap naturally at 2^32.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int q = 0; q < 4; q++) begin
                r_pkt_cnt[q] <= 32'd0;
            end
        end else begin
            for (int q = 0; q < 4; q++) begin
                if (w_pkt_done[q]) begin
                    r_pkt_cnt[q] <= r_pkt_cnt[q] + 32'd1;
                end else begin
                    r_pkt_cnt[q] <= r_pkt_cnt[q];
                end
            end
        end
    end

    // Dropped packet counter.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_drop_cnt <= 32'd0;
        end else if (w_drop_pkt) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign pkt_cnt_0 = r_pkt_cnt[0];
    assign pkt_cnt_1 = r_pkt_cnt[1];
    assign pkt_cnt_2 = r_pkt_cnt[2];
    assign pkt_cnt_3 = r_pkt_cnt[3];
    assign drop_cnt  = r_drop_cnt;
`else
    assign pkt_cnt_0 = 32'd0;
    assign pkt_cnt_1 = 32'd0;
    assign pkt_cnt_2 = 32'd0;
    assign pkt_cnt_3 = 32'd0;
    assign drop_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_queue_demux.sv
// Bench for pkt_queue_demux.
// Instance 0 has four queues and instance 1 has three queues, so qsel=3 is dropped on instance 1.
// A per-instance behavioural model predicts every output on every cycle.
// Directed scenarios and randomized packets drive both instances.

`timescale 1ns/1ps

module tb_pkt_queue_demux;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 32;
    localparam int QL = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata  [2];
    logic [KW-1:0] s_tkeep  [2];
    logic [UW-1:0] s_tuser  [2];
    logic          s_tlast  [2];
    logic          s_tvalid [2];
    logic          s_tready [2];

    logic          m_tready [2][4];
    logic [DW-1:0] m_tdata  [2][4];
    logic [KW-1:0] m_tkeep  [2][4];
    logic [UW-1:0] m_tuser  [2][4];
    logic          m_tlast  [2][4];
    logic          m_tvalid [2][4];
    logic [31:0]   pkt_cnt  [2][4];
    logic [31:0]   drop_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pkt_queue_demux #(
            .C_AXIS_DATA_WIDTH (DW),
            .C_AXIS_TUSER_WIDTH(UW),
            .C_NUM_QUEUES      ((g == 0) ? 4 : 3),
            .C_NUM_QUEUES_WIDTH(2),
            .C_QSEL_LSB        (QL)
        ) u_dut (
            .axis_clk       (clk),
            .aresetn        (rst_n),
            .s_axis_tdata   (s_tdata[g]),
            .s_axis_tkeep   (s_tkeep[g]),
            .s_axis_tuser   (s_tuser[g]),
            .s_axis_tlast   (s_tlast[g]),
            .s_axis_tvalid  (s_tvalid[g]),
            .s_axis_tready  (s_tready[g]),
            .m_axis_tdata_0 (m_tdata[g][0]),  .m_axis_tkeep_0 (m_tkeep[g][0]),
            .m_axis_tuser_0 (m_tuser[g][0]),  .m_axis_tlast_0 (m_tlast[g][0]),
            .m_axis_tvalid_0(m_tvalid[g][0]), .m_axis_tready_0(m_tready[g][0]),
            .m_axis_tdata_1 (m_tdata[g][1]),  .m_axis_tkeep_1 (m_tkeep[g][1]),
            .m_axis_tuser_1 (m_tuser[g][1]),  .m_axis_tlast_1 (m_tlast[g][1]),
            .m_axis_tvalid_1(m_tvalid[g][1]), .m_axis_tready_1(m_tready[g][1]),
            .m_axis_tdata_2 (m_tdata[g][2]),  .m_axis_tkeep_2 (m_tkeep[g][2]),
            .m_axis_tuser_2 (m_tuser[g][2]),  .m_axis_tlast_2 (m_tlast[g][2]),
            .m_axis_tvalid_2(m_tvalid[g][2]), .m_axis_tready_2(m_tready[g][2]),
            .m_axis_tdata_3 (m_tdata[g][3]),  .m_axis_tkeep_3 (m_tkeep[g][3]),
            .m_axis_tuser_3 (m_tuser[g][3]),  .m_axis_tlast_3 (m_tlast[g][3]),
            .m_axis_tvalid_3(m_tvalid[g][3]), .m_axis_tready_3(m_tready[g][3]),
            .pkt_cnt_0      (pkt_cnt[g][0]),
            .pkt_cnt_1      (pkt_cnt[g][1]),
            .pkt_cnt_2      (pkt_cnt[g][2]),
            .pkt_cnt_3      (pkt_cnt[g][3]),
            .drop_cnt       (drop_cnt[g])
        );
    end

    // Reference model: a one-beat holding slot per instance.
    // Each packet has a destination, or -1 when the packet is being discarded.
    logic          md_vld   [2];
    int            md_q     [2];
    logic [DW-1:0] md_data  [2];
    logic [KW-1:0] md_keep  [2];
    logic [UW-1:0] md_user  [2];
    logic          md_last  [2];
    bit            md_inpkt [2];
    int            md_dest  [2];
    logic [31:0]   md_pkt   [2][4];
    logic [31:0]   md_drop  [2];
    int            nq       [2] = '{4, 3};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit acc      [2];
    bit rdy_rand = 1'b0;
    bit gap_en   = 1'b0;
    int vseen    [2][4];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef QUEUE_DEMUX_CNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            md_vld[i] = 1'b0;  md_q[i] = 0;
            md_data[i] = '0;   md_keep[i] = '0;  md_user[i] = '0;  md_last[i] = 1'b0;
            md_inpkt[i] = 1'b0; md_dest[i] = 0;  md_drop[i] = 32'd0;
            for (int q = 0; q < 4; q++) md_pkt[i][q] = 32'd0;
        end
    endfunction

    function automatic bit exp_ready(input int i);
        if (md_inpkt[i] && md_dest[i] < 0) return 1'b1;
        return !md_vld[i] || m_tready[i][md_q[i]];
    endfunction

    function automatic void model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            bit drain;
            bit load;
            drain = md_vld[i] && m_tready[i][md_q[i]];
            load  = 1'b0;
            if (drain && md_last[i]) md_pkt[i][md_q[i]] = md_pkt[i][md_q[i]] + 32'd1;
            if (acc[i]) begin
                if (!md_inpkt[i]) begin
                    int qs;
                    qs = int'(s_tuser[i][QL +: 2]);
                    if (qs < nq[i]) begin
                        md_dest[i] = qs;
                    end else begin
                        md_dest[i] = -1;
                        md_drop[i] = md_drop[i] + 32'd1;
                    end
                end
                load        = (md_dest[i] >= 0);
                md_inpkt[i] = !s_tlast[i];
            end
            if (load) begin
                md_vld[i]  = 1'b1;        md_q[i]    = md_dest[i];
                md_data[i] = s_tdata[i];  md_keep[i] = s_tkeep[i];
                md_user[i] = s_tuser[i];  md_last[i] = s_tlast[i];
            end else if (drain) begin
                md_vld[i] = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("i%0d s_tready", i), 128'(s_tready[i]), 128'(exp_ready(i)));
            check_eq($sformatf("i%0d drop_cnt", i), 128'(drop_cnt[i]), 128'(cnt_exp(int'(md_drop[i]))));
            for (int q = 0; q < 4; q++) begin
                check_eq($sformatf("i%0d tvalid_%0d", i, q), 128'(m_tvalid[i][q]),
                         128'(md_vld[i] && md_q[i] == q));
                check_eq($sformatf("i%0d beat_%0d", i, q),
                         128'({m_tdata[i][q], m_tkeep[i][q], m_tuser[i][q], m_tlast[i][q]}),
                         128'({md_data[i], md_keep[i], md_user[i], md_last[i]}));
                check_eq($sformatf("i%0d pkt_cnt_%0d", i, q), 128'(pkt_cnt[i][q]),
                         128'(cnt_exp(int'(md_pkt[i][q]))));
            end
        end
    endtask

    // One clock: optional ready shuffle, compare at negedge, model advances on posedge.
    task automatic step();
        if (rdy_rand) begin
            for (int i = 0; i < 2; i++)
                for (int q = 0; q < 4; q++) m_tready[i][q] = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        check_all();
        for (int i = 0; i < 2; i++) begin
            acc[i] = s_tvalid[i] && exp_ready(i);
            for (int q = 0; q < 4; q++) if (m_tvalid[i][q]) vseen[i][q]++;
        end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 2; i++)
            for (int q = 0; q < 4; q++) vseen[i][q] = 0;
    endtask

    task automatic send_beat(input int i, input logic [DW-1:0] d, input logic [UW-1:0] u, input bit last);
        if (gap_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        s_tdata[i]  = d;
        s_tkeep[i]  = KW'($urandom);
        s_tuser[i]  = u;
        s_tlast[i]  = last;
        s_tvalid[i] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            step();
            if (acc[i]) begin
                s_tvalid[i] = 1'b0;
                return;
            end
        end
        check_eq($sformatf("i%0d accept_timeout", i), 128'd0, 128'd1);
        s_tvalid[i] = 1'b0;
    endtask

    // Sends one packet. When alt_user is set, later beats carry a random queue field.
    task automatic send_pkt(input int i, input int len, input int qsel, input bit alt_user);
        for (int b = 0; b < len; b++) begin
            logic [UW-1:0] u;
            u = UW'($urandom);
            u[QL +: 2] = (b == 0 || !alt_user) ? 2'(qsel) : 2'($urandom_range(0, 3));
            send_beat(i, {$urandom, $urandom}, u, (b == len - 1));
        end
    endtask

    task automatic drain(input int n);
        rdy_rand = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int q = 0; q < 4; q++) m_tready[i][q] = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        logic [DW-1:0] b2;
        logic [UW-1:0] u;
        int c0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tdata[i] = '0; s_tkeep[i] = '0; s_tuser[i] = '0;
            s_tlast[i] = 1'b0; s_tvalid[i] = 1'b0;
            for (int q = 0; q < 4; q++) m_tready[i][q] = 1'b1;
        end
        model_reset();
        clear_seen();
        repeat (3) step();
        rst_n = 1'b1;
        check_eq("reset s_tready", 128'(s_tready[0]), 128'd1);

        // 3-beat packet to queue 2 with all readys high.
        clear_seen();
        send_pkt(0, 3, 2, 1'b0);
        drain(3);
        check_eq("t1 tvalid_2 cycles", 128'(vseen[0][2]), 128'd3);
        check_eq("t1 other tvalids", 128'(vseen[0][0] + vseen[0][1] + vseen[0][3]), 128'd0);
        check_eq("t1 pkt_cnt_2", 128'(pkt_cnt[0][2]), 128'(cnt_exp(1)));

        // Back-to-back single-beat packets to queues 0,1,2,3,0.
        c0 = cyc;
        send_pkt(0, 1, 0, 1'b0);
        send_pkt(0, 1, 1, 1'b0);
        send_pkt(0, 1, 2, 1'b0);
        send_pkt(0, 1, 3, 1'b0);
        send_pkt(0, 1, 0, 1'b0);
        check_eq("t2 cycles for 5 beats", 128'(cyc - c0), 128'd5);
        drain(2);
        check_eq("t2 pkt_cnt_0", 128'(pkt_cnt[0][0]), 128'(cnt_exp(2)));

        // 4-beat packet to queue 1 with its ready held low for 5 cycles after beat 2.
        u = '0; u[QL +: 2] = 2'd1;
        send_beat(0, 64'h1111_0000_0000_0001, u, 1'b0);
        b2 = 64'h2222_0000_0000_0002;
        send_beat(0, b2, u, 1'b0);
        m_tready[0][1] = 1'b0;
        s_tdata[0] = 64'h3333_0000_0000_0003; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
        repeat (5) step();
        check_eq("t3 stall s_tready", 128'(s_tready[0]), 128'd0);
        check_eq("t3 held beat2", 128'(m_tdata[0][1]), 128'(b2));
        check_eq("t3 held tvalid_1", 128'(m_tvalid[0][1]), 128'd1);
        m_tready[0][1] = 1'b1;
        send_beat(0, 64'h3333_0000_0000_0003, u, 1'b0);
        send_beat(0, 64'h4444_0000_0000_0004, u, 1'b1);
        drain(3);

        // Later beats carry a different queue field and must still go to queue 3.
        clear_seen();
        u = '0; u[QL +: 2] = 2'd3;
        send_beat(0, 64'hA, u, 1'b0);
        u[QL +: 2] = 2'd0;
        send_beat(0, 64'hB, u, 1'b0);
        send_beat(0, 64'hC, u, 1'b1);
        drain(3);
        check_eq("t4 beats on q3", 128'(vseen[0][3]), 128'd3);
        check_eq("t4 beats on q0", 128'(vseen[0][0]), 128'd0);

        // Three-queue instance: qsel=3 packet dropped, qsel=0 packet forwarded.
        clear_seen();
        send_pkt(1, 2, 3, 1'b0);
        send_pkt(1, 2, 0, 1'b0);
        drain(3);
        check_eq("t5 drop_cnt", 128'(drop_cnt[1]), 128'(cnt_exp(1)));
        check_eq("t5 dropped tvalid_3", 128'(vseen[1][3]), 128'd0);
        check_eq("t5 q0 beats", 128'(vseen[1][0]), 128'd2);
        check_eq("t5 pkt_cnt_0", 128'(pkt_cnt[1][0]), 128'(cnt_exp(1)));

        // Reset asserted while beat 2 of 4 is presented.
        u = '0; u[QL +: 2] = 2'd2;
        send_beat(0, 64'h5, u, 1'b0);
        s_tdata[0] = 64'h6; s_tuser[0] = u; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6 reset tvalid_2", 128'(m_tvalid[0][2]), 128'd0);
        check_eq("t6 reset tdata", 128'(m_tdata[0][2]), 128'd0);
        check_eq("t6 reset pkt_cnt_0", 128'(pkt_cnt[0][0]), 128'd0);
        check_eq("t6 reset s_tready", 128'(s_tready[0]), 128'd1);
        model_reset();
        s_tvalid[0] = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        clear_seen();
        send_pkt(0, 1, 1, 1'b0);
        drain(3);
        check_eq("t6 new pkt on q1", 128'(vseen[0][1]), 128'd1);
        check_eq("t6 pkt_cnt_1", 128'(pkt_cnt[0][1]), 128'(cnt_exp(1)));
        check_eq("t6 pkt_cnt_2 restart", 128'(pkt_cnt[0][2]), 128'd0);

        // Randomized packets with random back-pressure and valid gaps.
        gap_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rdy_rand = 1'b1;
            for (int p = 0; p < 150; p++) send_pkt(i, $urandom_range(1, 5), $urandom_range(0, 3), 1'b1);
            drain(4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
